ex_forward_ctrl: RTL and testbench
==================================

# ex_forward_ctrl

Execute-stage hazard and forwarding controller for the 5-stage MIPS-16b pipeline. It tracks the destination register and write/load flags of the instructions leaving execute through its own EX/MEM and MEM/WB shadow registers. From these it drives the 2-bit forwarding-mux selects consumed by the execute stage, and detects load-use hazards to stall fetch/decode and inject a bubble. A saturating stall-cycle counter is kept for performance debug.

## Interface
Parameters:
- `STALL_CNT_W`, 16, width of the stall-cycle counter

Ports:
- `clk`  in  1  pipeline clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `ex_valid`  in  1  EX slot holds a live (non-bubble, non-flushed) instruction
- `ex_rs`, `ex_rt`  in  5 each  source registers of the instruction in EX
- `ex_dest_reg`  in  5  destination register of the EX instruction (post reg_dest mux)
- `ex_reg_write`  in  1  EX instruction writes the register file
- `ex_mem_read`  in  1  EX instruction is a load
- `id_rs`, `id_rt`  in  5 each  source registers of the instruction in ID
- `id_uses_rt`  in  1  ID instruction reads rt as a source (R-type, store, branch)
- `mem_wait`  in  1  data memory busy; the whole pipeline freezes
- `stat_clr`  in  1  synchronous clear of `stall_count`
- `forwd_mux1_ctrl`  out  2  ALU input 1 select: 00 register data, 01 wb_w_data, 10 mem_alu_out
- `forwd_mux2_ctrl`  out  2  same encoding for the rt/ALU input 2 path
- `stall`  out  1  hold PC and IF/ID register
- `bubble`  out  1  zero control fields loaded into ID/EX
- `stall_count`  out  `STALL_CNT_W`  cycles with `stall`=1, saturating

## Operation
- Shadow state: `mem_dest[4:0]`, `mem_rw`, `mem_ld` (EX/MEM copy) and `wb_dest[4:0]`, `wb_rw` (MEM/WB copy).
- On each rising edge with `mem_wait`=0:
  - `mem_dest`<=`ex_dest_reg`, `mem_rw`<=`ex_reg_write & ex_valid`, `mem_ld`<=`ex_mem_read & ex_valid`.
  - `wb_dest`<=`mem_dest`, `wb_rw`<=`mem_rw`.
- With `mem_wait`=1, all shadow registers hold.
- Forwarding for `forwd_mux1_ctrl`, and identically for mux2 using `ex_rt`:
  - 10 if `mem_rw` and `mem_dest`!=0 and `mem_dest`==`ex_rs`;
  - else 01 if `wb_rw` and `wb_dest`!=0 and `wb_dest`==`ex_rs`;
  - else 00.
  - The MEM match has priority over the WB match (the younger result wins).
  - Both selects are forced to 00 when `ex_valid`=0.
- Register 0 is never forwarded and never causes a hazard.
- Load-use: `lu` = `ex_valid & ex_mem_read & (ex_dest_reg!=0) & ((ex_dest_reg==id_rs) | (id_uses_rt & ex_dest_reg==id_rt))`.
- `stall` = `lu | mem_wait`.
- `bubble` = `lu & ~mem_wait`. While frozen, no bubble is injected; the hazard is re-evaluated after `mem_wait` drops.
- After a one-cycle load-use stall, the load sits in MEM/WB, so the dependent instruction in EX receives select 01. A load is never forwarded from `mem_alu_out`. `mem_ld` is used only for assertion checking: select 10 with `mem_ld`=1 is a design error.
- `stall_count`:
  - increments by 1 on each edge where `stall`=1;
  - saturates at all-ones;
  - `stat_clr` forces it to 0 and has priority over increment.

## Timing
- Reset (asynchronous, `rst_n`=0): all shadow registers are 0, so `forwd_mux1_ctrl`/`forwd_mux2_ctrl` = 00 and `stall_count` = 0. `stall`/`bubble` follow the inputs combinationally and are 0 whenever `ex_valid`=0 and `mem_wait`=0.
- Release of reset is taken on the first rising edge with `rst_n`=1. Asserting reset mid-stall drops all forwarding immediately.
- Forwarding selects, `stall` and `bubble` are combinational, valid in the same cycle as their inputs. They must settle before the rising edge that loads the pipeline registers.
- Shadow-register latency is one cycle per stage: an instruction in EX at cycle n is forwardable via 10 at n+1 and via 01 at n+2.
- A `mem_wait` pulse of k cycles delays forwarding availability by exactly k cycles.
- Simultaneous `stat_clr` and `stall`: the counter reads 0 after the edge.

## Test plan
- Back-to-back ALU dependency:
  - `add r3` in EX (`ex_reg_write`=1, dest 3);
  - next cycle `ex_rs`=3 -> `forwd_mux1_ctrl`=10;
  - cycle after with `ex_rt`=3 -> `forwd_mux2_ctrl`=01.
- Double hit: `mem_dest`=`wb_dest`=5, both rw=1, `ex_rs`=5 -> 10 (MEM priority). Repeat with dest 0 -> 00.
- Load-use: `ex_mem_read`=1, `ex_dest_reg`=7, `id_rs`=7 -> `stall`=1, `bubble`=1 for exactly 1 cycle. Then with the dependent instruction in EX, `ex_rs`=7 -> select 01 and `stall`=0.
- `id_uses_rt`=0 with `id_rt`=7 matching the load destination -> no stall.
- `mem_wait` held 3 cycles during a dependency chain -> shadow registers unchanged, `stall`=1, `bubble`=0, `stall_count` +3.
- Saturation: preload the counter to 0xFFFE, stall 3 cycles -> 0xFFFF. Then `stat_clr` together with `stall` -> 0. Async reset mid-sequence -> all selects 00 immediately.

Source files
------------

// File: rtl/ex_forward_ctrl_if.sv
// EX-stage hazard/forwarding bundle between the pipeline and the controller.
// master = pipeline datapath side, slave = ex_forward_ctrl.
interface ex_forward_ctrl_if #(
  parameter int STALL_CNT_W = 16
);
  logic                   ex_valid;
  logic [4:0]             ex_rs;
  logic [4:0]             ex_rt;
  logic [4:0]             ex_dest_reg;
  logic                   ex_reg_write;
  logic                   ex_mem_read;
  logic [4:0]             id_rs;
  logic [4:0]             id_rt;
  logic                   id_uses_rt;
  logic                   mem_wait;
  logic                   stat_clr;
  logic [1:0]             forwd_mux1_ctrl;
  logic [1:0]             forwd_mux2_ctrl;
  logic                   stall;
  logic                   bubble;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output ex_valid,
    output ex_rs,
    output ex_rt,
    output ex_dest_reg,
    output ex_reg_write,
    output ex_mem_read,
    output id_rs,
    output id_rt,
    output id_uses_rt,
    output mem_wait,
    output stat_clr,
    input  forwd_mux1_ctrl,
    input  forwd_mux2_ctrl,
    input  stall,
    input  bubble,
    input  stall_count
  );

  modport slave (
    input  ex_valid,
    input  ex_rs,
    input  ex_rt,
    input  ex_dest_reg,
    input  ex_reg_write,
    input  ex_mem_read,
    input  id_rs,
    input  id_rt,
    input  id_uses_rt,
    input  mem_wait,
    input  stat_clr,
    output forwd_mux1_ctrl,
    output forwd_mux2_ctrl,
    output stall,
    output bubble,
    output stall_count
  );
endinterface

// File: rtl/ex_forward_ctrl.sv
// EX-stage forwarding select and load-use hazard controller
// with private EX/MEM and MEM/WB shadows and a stall counter.
module ex_forward_ctrl #(
  parameter int STALL_CNT_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  ex_forward_ctrl_if.slave fwd
);

  typedef struct packed {
    logic [4:0] dest;
    logic       rw;
    logic       ld;
  } mem_sh_t;

  typedef struct packed {
    logic [4:0] dest;
    logic       rw;
  } wb_sh_t;

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [STALL_CNT_W-1:0] CNT_ONE =
    {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  mem_sh_t                mem_q, mem_d;
  wb_sh_t                 wb_q, wb_d;
  logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

  logic       mem_hit1, wb_hit1;
  logic       mem_hit2, wb_hit2;
  logic [1:0] sel1, sel2;
  logic       id_rs_hit, id_rt_hit;
  logic       lu;
  logic       stall;
  logic       bubble;

  // Hits are made mutually exclusive so MEM (younger) wins over WB.
  always_comb begin
    mem_hit1 = fwd.ex_valid && mem_q.rw &&
               (mem_q.dest != 5'd0) &&
               (mem_q.dest == fwd.ex_rs);
    mem_hit2 = fwd.ex_valid && mem_q.rw &&
               (mem_q.dest != 5'd0) &&
               (mem_q.dest == fwd.ex_rt);
    wb_hit1  = fwd.ex_valid && wb_q.rw &&
               (wb_q.dest != 5'd0) &&
               (wb_q.dest == fwd.ex_rs) && !mem_hit1;
    wb_hit2  = fwd.ex_valid && wb_q.rw &&
               (wb_q.dest != 5'd0) &&
               (wb_q.dest == fwd.ex_rt) && !mem_hit2;
  end

  always_comb begin
    sel1 = SEL_REG;
    unique case (1'b1)
      mem_hit1: sel1 = SEL_MEM;
      wb_hit1:  sel1 = SEL_WB;
      default:  sel1 = SEL_REG;
    endcase
  end

  always_comb begin
    sel2 = SEL_REG;
    unique case (1'b1)
      mem_hit2: sel2 = SEL_MEM;
      wb_hit2:  sel2 = SEL_WB;
      default:  sel2 = SEL_REG;
    endcase
  end

  always_comb begin
    id_rs_hit = (fwd.ex_dest_reg == fwd.id_rs);
    id_rt_hit = fwd.id_uses_rt &&
                (fwd.ex_dest_reg == fwd.id_rt);
    lu        = fwd.ex_valid && fwd.ex_mem_read &&
                (fwd.ex_dest_reg != 5'd0) &&
                (id_rs_hit || id_rt_hit);
    stall     = lu || fwd.mem_wait;
    bubble    = lu && !fwd.mem_wait;
  end

  always_comb begin
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!fwd.mem_wait) begin
      mem_d.dest = fwd.ex_dest_reg;
      mem_d.rw   = fwd.ex_reg_write && fwd.ex_valid;
      mem_d.ld   = fwd.ex_mem_read && fwd.ex_valid;
      wb_d.dest  = mem_q.dest;
      wb_d.rw    = mem_q.rw;
    end
  end

  // Clear beats increment when both happen on the same edge.
  always_comb begin
    cnt_d = cnt_q;
    if (fwd.stat_clr) begin
      cnt_d = '0;
    end else if (stall && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign fwd.forwd_mux1_ctrl = sel1;
  assign fwd.forwd_mux2_ctrl = sel2;
  assign fwd.stall           = stall;
  assign fwd.bubble          = bubble;
  assign fwd.stall_count     = cnt_q;

  // A load result only exists at MEM/WB; mem_alu_out never carries it.
  a_no_load_from_mem : assert property (
    @(posedge clk) disable iff (!rst_n)
    !(mem_q.ld && ((sel1 == SEL_MEM) || (sel2 == SEL_MEM)))
  );

  a_bubble_implies_stall : assert property (
    @(posedge clk) disable iff (!rst_n)
    bubble |-> stall
  );

endmodule

// File: tb/tb_ex_forward_ctrl.sv
// Self-checking bench for ex_forward_ctrl: directed scenarios plus
// randomized traffic against a producer-history reference model.
module tb_ex_forward_ctrl;

  localparam int W    = 16;
  localparam int CMAX = (1 << W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  ex_forward_ctrl_if #(.STALL_CNT_W(W)) bus ();

  ex_forward_ctrl #(.STALL_CNT_W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fwd   (bus)
  );

  typedef struct {
    int dest;
    bit rw;
    bit ld;
  } prod_t;

  // hist[0] = most recent instruction to leave EX, hist[1] = the one before
  prod_t hist[$];
  int    m_cnt;
  int    n_vec;
  int    n_err;

  task automatic model_reset();
    prod_t z;
    z.dest = 0;
    z.rw   = 1'b0;
    z.ld   = 1'b0;
    hist.delete();
    hist.push_back(z);
    hist.push_back(z);
    m_cnt = 0;
  endtask

  function automatic int exp_sel(int src);
    if (!bus.ex_valid) return 0;
    for (int i = 0; i < 2; i++) begin
      if (hist[i].rw && hist[i].dest != 0 && hist[i].dest == src)
        return (i == 0) ? 2 : 1;
    end
    return 0;
  endfunction

  function automatic bit exp_lu();
    int d;
    d = int'(bus.ex_dest_reg);
    if (!(bus.ex_valid && bus.ex_mem_read) || d == 0) return 1'b0;
    if (d == int'(bus.id_rs)) return 1'b1;
    return bus.id_uses_rt && d == int'(bus.id_rt);
  endfunction

  task automatic set_ex(bit v, int rs, int rt, int dest, bit rw, bit ld);
    bus.ex_valid     = v;
    bus.ex_rs        = 5'(rs);
    bus.ex_rt        = 5'(rt);
    bus.ex_dest_reg  = 5'(dest);
    bus.ex_reg_write = rw;
    bus.ex_mem_read  = ld;
  endtask

  task automatic set_id(int rs, int rt, bit ut);
    bus.id_rs      = 5'(rs);
    bus.id_rt      = 5'(rt);
    bus.id_uses_rt = ut;
  endtask

  // One rising edge; the model advances from the inputs present before it.
  task automatic tick();
    bit    st;
    prod_t p;
    st = exp_lu() || bus.mem_wait;
    p.dest = int'(bus.ex_dest_reg);
    p.rw   = bus.ex_reg_write && bus.ex_valid;
    p.ld   = bus.ex_mem_read && bus.ex_valid;
    @(posedge clk);
    if (bus.stat_clr) m_cnt = 0;
    else if (st && m_cnt < CMAX) m_cnt++;
    if (!bus.mem_wait) begin
      hist.push_front(p);
      void'(hist.pop_back());
    end
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    bus.mem_wait = 1'b0;
    bus.stat_clr = 1'b0;
    set_ex(1'b1, 3, 4, 7, 1'b1, 1'b1);
    set_id(7, 0, 1'b0);
    #1;
    n_vec++;
    if (bus.forwd_mux1_ctrl !== 2'b00 || bus.forwd_mux2_ctrl !== 2'b00) begin
      n_err++;
      $display("FAIL reset_sel: got %b/%b want 00/00",
               bus.forwd_mux1_ctrl, bus.forwd_mux2_ctrl);
    end
    n_vec++;
    if (bus.stall_count !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_cnt: got %h want 0000", bus.stall_count);
    end
    n_vec++;
    if (bus.stall !== 1'b1 || bus.bubble !== 1'b1) begin
      n_err++;
      $display("FAIL reset_lu_comb: got stall=%b bubble=%b want 1/1",
               bus.stall, bus.bubble);
    end
    set_ex(1'b0, 0, 0, 0, 1'b0, 1'b0);
    set_id(0, 0, 1'b0);
    #1;
    n_vec++;
    if (bus.stall !== 1'b0 || bus.bubble !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: got stall=%b bubble=%b want 0/0",
               bus.stall, bus.bubble);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    set_id(0, 0, 1'b0);
    set_ex(1'b1, 1, 2, 3, 1'b1, 1'b0);
    tick();
    set_ex(1'b1, 3, 9, 4, 1'b1, 1'b0);
    #1;
    n_vec++;
    if (bus.forwd_mux1_ctrl !== 2'b10 || bus.forwd_mux2_ctrl !== 2'b00) begin
      n_err++;
      $display("FAIL b2b_mem: got %b/%b want 10/00",
               bus.forwd_mux1_ctrl, bus.forwd_mux2_ctrl);
    end
    tick();
    set_ex(1'b1, 8, 3, 5, 1'b1, 1'b0);
    #1;
    n_vec++;
    if (bus.forwd_mux1_ctrl !== 2'b00 || bus.forwd_mux2_ctrl !== 2'b01) begin
      n_err++;
      $display("FAIL b2b_wb: got %b/%b want 00/01",
               bus.forwd_mux1_ctrl, bus.forwd_mux2_ctrl);
    end
    set_ex(1'b0, 8, 3, 5, 1'b1, 1'b0);
    #1;
    n_vec++;
    if (bus.forwd_mux2_ctrl !== 2'b00) begin
      n_err++;
      $display("FAIL b2b_invalid: got %b want 00", bus.forwd_mux2_ctrl);
    end
    tick();
  endtask

  task automatic test_double_hit();
    set_ex(1'b1, 0, 0, 5, 1'b1, 1'b0);
    tick();
    tick();
    set_ex(1'b1, 5, 5, 0, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (bus.forwd_mux1_ctrl !== 2'b10 || bus.forwd_mux2_ctrl !== 2'b10) begin
      n_err++;
      $display("FAIL dbl_hit: got %b/%b want 10/10",
               bus.forwd_mux1_ctrl, bus.forwd_mux2_ctrl);
    end
    set_ex(1'b1, 0, 0, 0, 1'b1, 1'b0);
    tick();
    tick();
    #1;
    n_vec++;
    if (bus.forwd_mux1_ctrl !== 2'b00 || bus.forwd_mux2_ctrl !== 2'b00) begin
      n_err++;
      $display("FAIL dbl_hit_r0: got %b/%b want 00/00",
               bus.forwd_mux1_ctrl, bus.forwd_mux2_ctrl);
    end
  endtask

  task automatic test_load_use();
    int c0;
    c0 = m_cnt;
    set_ex(1'b1, 1, 2, 7, 1'b1, 1'b1);
    set_id(7, 0, 1'b0);
    #1;
    n_vec++;
    if (bus.stall !== 1'b1 || bus.bubble !== 1'b1) begin
      n_err++;
      $display("FAIL lu_detect: got stall=%b bubble=%b want 1/1",
               bus.stall, bus.bubble);
    end
    tick();
    set_ex(1'b0, 0, 0, 0, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (bus.stall !== 1'b0 || bus.bubble !== 1'b0) begin
      n_err++;
      $display("FAIL lu_one_cycle: got stall=%b bubble=%b want 0/0",
               bus.stall, bus.bubble);
    end
    tick();
    set_ex(1'b1, 7, 0, 8, 1'b1, 1'b0);
    set_id(0, 0, 1'b0);
    #1;
    n_vec++;
    if (bus.forwd_mux1_ctrl !== 2'b01 || bus.stall !== 1'b0) begin
      n_err++;
      $display("FAIL lu_fwd_wb: got sel=%b stall=%b want 01/0",
               bus.forwd_mux1_ctrl, bus.stall);
    end
    n_vec++;
    if (bus.stall_count !== 16'(c0 + 1)) begin
      n_err++;
      $display("FAIL lu_cnt: got %0d want %0d", bus.stall_count, c0 + 1);
    end
    tick();
  endtask

  task automatic test_no_rt();
    set_ex(1'b1, 0, 0, 7, 1'b1, 1'b1);
    set_id(1, 7, 1'b0);
    #1;
    n_vec++;
    if (bus.stall !== 1'b0) begin
      n_err++;
      $display("FAIL no_rt: got stall=%b want 0", bus.stall);
    end
    bus.id_uses_rt = 1'b1;
    #1;
    n_vec++;
    if (bus.stall !== 1'b1) begin
      n_err++;
      $display("FAIL uses_rt: got stall=%b want 1", bus.stall);
    end
    set_ex(1'b0, 0, 0, 0, 1'b0, 1'b0);
    set_id(0, 0, 1'b0);
    tick();
    tick();
  endtask

  task automatic test_mem_wait();
    int c0;
    set_ex(1'b1, 1, 2, 3, 1'b1, 1'b0);
    set_id(0, 0, 1'b0);
    tick();
    c0 = m_cnt;
    set_ex(1'b1, 3, 0, 4, 1'b1, 1'b1);
    set_id(4, 0, 1'b0);
    bus.mem_wait = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_vec++;
      if (bus.forwd_mux1_ctrl !== 2'b10 || bus.stall !== 1'b1 ||
          bus.bubble !== 1'b0) begin
        n_err++;
        $display("FAIL mw_hold[%0d]: got sel=%b stall=%b bubble=%b want 10/1/0",
                 k, bus.forwd_mux1_ctrl, bus.stall, bus.bubble);
      end
      tick();
    end
    n_vec++;
    if (bus.stall_count !== 16'(c0 + 3)) begin
      n_err++;
      $display("FAIL mw_cnt: got %0d want %0d", bus.stall_count, c0 + 3);
    end
    bus.mem_wait = 1'b0;
    #1;
    n_vec++;
    if (bus.forwd_mux1_ctrl !== 2'b10 || bus.stall !== 1'b1 ||
        bus.bubble !== 1'b1) begin
      n_err++;
      $display("FAIL mw_release: got sel=%b stall=%b bubble=%b want 10/1/1",
               bus.forwd_mux1_ctrl, bus.stall, bus.bubble);
    end
    set_ex(1'b0, 0, 0, 0, 1'b0, 1'b0);
    set_id(0, 0, 1'b0);
    tick();
    tick();
  endtask

  task automatic test_random();
    int e1, e2, d;
    bit es, eb;
    for (int n = 0; n < 400; n++) begin
      set_ex($urandom_range(3, 0) != 0, $urandom_range(7, 0),
             $urandom_range(7, 0), $urandom_range(7, 0),
             $urandom_range(1, 0), $urandom_range(3, 0) == 0);
      if (bus.ex_mem_read) bus.ex_reg_write = 1'b1;
      set_id($urandom_range(7, 0), $urandom_range(7, 0),
             $urandom_range(1, 0));
      bus.mem_wait = $urandom_range(3, 0) == 0;
      bus.stat_clr = $urandom_range(15, 0) == 0;
      // a real pipeline never lets a load's consumer reach EX one behind it
      d = hist[0].dest;
      if (hist[0].ld && d != 0) begin
        if (int'(bus.ex_rs) == d) bus.ex_rs = 5'((d + 1) % 32);
        if (int'(bus.ex_rt) == d) bus.ex_rt = 5'((d + 1) % 32);
      end
      #1;
      e1 = exp_sel(int'(bus.ex_rs));
      e2 = exp_sel(int'(bus.ex_rt));
      es = exp_lu() || bus.mem_wait;
      eb = exp_lu() && !bus.mem_wait;
      n_vec++;
      if (bus.forwd_mux1_ctrl !== 2'(e1) || bus.forwd_mux2_ctrl !== 2'(e2)) begin
        n_err++;
        $display("FAIL rnd_sel[%0d]: got %b/%b want %0d/%0d",
                 n, bus.forwd_mux1_ctrl, bus.forwd_mux2_ctrl, e1, e2);
      end
      n_vec++;
      if (bus.stall !== es || bus.bubble !== eb) begin
        n_err++;
        $display("FAIL rnd_hz[%0d]: got %b/%b want %b/%b",
                 n, bus.stall, bus.bubble, es, eb);
      end
      tick();
      n_vec++;
      if (bus.stall_count !== 16'(m_cnt)) begin
        n_err++;
        $display("FAIL rnd_cnt[%0d]: got %0d want %0d",
                 n, bus.stall_count, m_cnt);
      end
    end
    bus.mem_wait = 1'b0;
    bus.stat_clr = 1'b0;
    set_ex(1'b0, 0, 0, 0, 1'b0, 1'b0);
    set_id(0, 0, 1'b0);
    tick();
    tick();
  endtask

  task automatic test_saturation();
    bus.stat_clr = 1'b1;
    tick();
    bus.stat_clr = 1'b0;
    bus.mem_wait = 1'b1;
    repeat (CMAX - 1) tick();
    n_vec++;
    if (bus.stall_count !== 16'hFFFE) begin
      n_err++;
      $display("FAIL sat_pre: got %h want fffe", bus.stall_count);
    end
    repeat (3) tick();
    n_vec++;
    if (bus.stall_count !== 16'hFFFF || m_cnt != CMAX) begin
      n_err++;
      $display("FAIL sat_hold: got %h want ffff", bus.stall_count);
    end
    bus.stat_clr = 1'b1;
    tick();
    n_vec++;
    if (bus.stall_count !== 16'h0000) begin
      n_err++;
      $display("FAIL sat_clr: got %h want 0000", bus.stall_count);
    end
    bus.stat_clr = 1'b0;
    bus.mem_wait = 1'b0;
  endtask

  task automatic test_async_reset();
    set_ex(1'b1, 0, 0, 6, 1'b1, 1'b0);
    tick();
    set_ex(1'b1, 6, 6, 0, 1'b0, 1'b0);
    bus.mem_wait = 1'b1;
    tick();
    #1;
    n_vec++;
    if (bus.forwd_mux1_ctrl !== 2'b10 || bus.stall_count === 16'h0000) begin
      n_err++;
      $display("FAIL arst_pre: got sel=%b cnt=%h want 10/nonzero",
               bus.forwd_mux1_ctrl, bus.stall_count);
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if (bus.forwd_mux1_ctrl !== 2'b00 || bus.forwd_mux2_ctrl !== 2'b00 ||
        bus.stall_count !== 16'h0000) begin
      n_err++;
      $display("FAIL arst_now: got %b/%b cnt=%h want 00/00 0000",
               bus.forwd_mux1_ctrl, bus.forwd_mux2_ctrl, bus.stall_count);
    end
    bus.mem_wait = 1'b0;
    set_ex(1'b0, 0, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_back_to_back();
    test_double_hit();
    test_load_use();
    test_no_rt();
    test_mem_wait();
    test_random();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
